otp_stream_cypher: RTL and testbench

OTP_STREAM_CYPHER -- requirements
Module: otp_stream_cypher

---
 rtl/otp_stream_cypher.sv | 108 ++++++++++
 tb/tb_otp_stream_cypher.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/otp_stream_cypher.sv
// Key-XOR stream cipher: one KEY_W block per cycle MSB-first, optional per-block key rotation.
// Latency NBLK cycles accept-to-out_valid; result held in DONE until out_ready, no request queuing.
module otp_stream_cypher #(
   parameter int KEY_W = 16,
   parameter int MSG_W = 240
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [MSG_W-1:0] msg,
   input  logic [KEY_W-1:0] key,
   input  logic             rotate,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [MSG_W-1:0] out,
   output logic             busy
);

   localparam int NBLK  = MSG_W / KEY_W;
   localparam int CNT_W = (NBLK > 1) ? $clog2(NBLK) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NBLK - 1);

   generate
      if ((MSG_W % KEY_W) != 0 || NBLK < 1) begin : g_bad_params
         $error("otp_stream_cypher: MSG_W must be a non-zero multiple of KEY_W");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [MSG_W-1:0] msg_q;
   logic [MSG_W-1:0] acc_q;
   logic [MSG_W-1:0] out_q;
   logic [KEY_W-1:0] key_q;
   logic             mode_q;
   logic [CNT_W-1:0] cnt_q;

   logic [KEY_W-1:0] xor_blk;
   logic [KEY_W-1:0] key_rot;
   logic [MSG_W-1:0] acc_next;

   assign xor_blk  = msg_q[MSG_W-1 -: KEY_W] ^ key_q;
   // Written with shifts so a 1-bit key still elaborates cleanly.
   assign key_rot  = (key_q << 1) | (key_q >> (KEY_W - 1));
   assign acc_next = (acc_q << KEY_W) | MSG_W'(xor_blk);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (cnt_q == LAST) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msg_q  <= '0;
         acc_q  <= '0;
         out_q  <= '0;
         key_q  <= '0;
         mode_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  msg_q  <= msg;
                  key_q  <= key;
                  mode_q <= rotate;
                  acc_q  <= '0;
                  cnt_q  <= '0;
               end
            end
            RUN: begin
               msg_q <= msg_q << KEY_W;
               acc_q <= acc_next;
               cnt_q <= cnt_q + CNT_W'(1);
               if (mode_q) key_q <= key_rot;
               if (cnt_q == LAST) out_q <= acc_next;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out       = out_q;

endmodule

// File: tb/tb_otp_stream_cypher.sv
// Bench for otp_stream_cypher: 48-bit instance for vectors and corner cases, default-size instance for round trips.
module tb_otp_stream_cypher;

   localparam int SK = 16;
   localparam int SM = 48;
   localparam int SN = 3;
   localparam int BK = 16;
   localparam int BM = 240;
   localparam int BN = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          s_in_valid = 1'b0, s_in_ready, s_rotate = 1'b0;
   logic          s_out_valid, s_out_ready = 1'b0, s_busy;
   logic [SM-1:0] s_msg = '0, s_out;
   logic [SK-1:0] s_key = '0;

   logic          b_in_valid = 1'b0, b_in_ready, b_rotate = 1'b0;
   logic          b_out_valid, b_out_ready = 1'b0, b_busy;
   logic [BM-1:0] b_msg = '0, b_out;
   logic [BK-1:0] b_key = '0;

   otp_stream_cypher #(.KEY_W(SK), .MSG_W(SM)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .msg(s_msg), .key(s_key), .rotate(s_rotate), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out(s_out), .busy(s_busy));

   otp_stream_cypher #(.KEY_W(BK), .MSG_W(BM)) dut_big (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .msg(b_msg), .key(b_key), .rotate(b_rotate), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out(b_out), .busy(b_busy));

   int checks = 0;
   int errors = 0;
   logic [SM-1:0] s_q[$];
   logic [BM-1:0] b_q[$];

   typedef struct {
      logic [SM-1:0] m;
      logic [SK-1:0] k;
      logic          r;
      logic [SM-1:0] exp;
   } vec_t;
   vec_t tbl[5];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [BM-1:0] model_big(input logic [BM-1:0] m, input logic [BK-1:0] k,
                                                input logic r);
      logic [BM-1:0] res;
      logic [BK-1:0] kk;
      res = '0;
      kk  = k;
      for (int i = 0; i < BN; i++) begin
         res[BM-1-i*BK -: BK] = m[BM-1-i*BK -: BK] ^ kk;
         if (r) kk = {kk[BK-2:0], kk[BK-1]};
      end
      return res;
   endfunction

   // Called at a negedge with the small DUT idle; out_ready is held high the whole time.
   task automatic small_req(input logic [SM-1:0] m, input logic [SK-1:0] k, input logic r,
                            input logic [SM-1:0] exp, input string name);
      int cyc;
      logic [SM-1:0] e;
      check({name, " in_ready"}, 256'(s_in_ready), 256'(1));
      s_msg = m; s_key = k; s_rotate = r; s_in_valid = 1'b1; s_out_ready = 1'b1;
      @(posedge clk);
      s_q.push_back(exp);
      @(negedge clk);
      s_in_valid = 1'b0; s_msg = ~m; s_key = ~k; s_rotate = ~r;
      cyc = 0;
      while (!s_out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({name, " latency"}, 256'(cyc), 256'(SN));
      e = (s_q.size() > 0) ? s_q.pop_front() : 'x;
      check({name, " out"}, 256'(s_out), 256'(e));
      @(negedge clk);
      check({name, " idle after handshake"}, 256'({s_out_valid, s_in_ready, s_busy}), 256'(3'b010));
      check({name, " out held"}, 256'(s_out), 256'(e));
   endtask

   task automatic big_req(input logic [BM-1:0] m, input logic [BK-1:0] k, input logic r,
                          output logic [BM-1:0] res);
      int cyc;
      logic [BM-1:0] e;
      b_msg = m; b_key = k; b_rotate = r; b_in_valid = 1'b1; b_out_ready = 1'b1;
      @(posedge clk);
      b_q.push_back(model_big(m, k, r));
      @(negedge clk);
      b_in_valid = 1'b0; b_msg = ~m;
      cyc = 0;
      while (!b_out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("big latency", 256'(cyc), 256'(BN));
      e = (b_q.size() > 0) ? b_q.pop_front() : 'x;
      check("big out", 256'(b_out), 256'(e));
      res = b_out;
      @(negedge clk);
   endtask

   initial begin
      int cyc;
      logic [SM-1:0] held;
      logic [255:0]  rnd;
      logic [BM-1:0] m, c, p;
      logic [BK-1:0] k;
      logic          r;

      tbl[0] = '{48'h1234_5678_9ABC, 16'hFFFF, 1'b0, 48'hEDCB_A987_6543};
      tbl[1] = '{48'h0000_0000_0000, 16'h8001, 1'b1, 48'h8001_0003_0006};
      tbl[2] = '{48'hFFFF_FFFF_FFFF, 16'hAAAA, 1'b1, 48'h5555_AAAA_5555};
      tbl[3] = '{48'h0000_0000_0000, 16'h0001, 1'b1, 48'h0001_0002_0004};
      tbl[4] = '{48'hEDCB_A987_6543, 16'hFFFF, 1'b0, 48'h1234_5678_9ABC};

      #1;
      check("reset small", 256'({s_in_ready, s_out_valid, s_busy, s_out}), 256'({3'b100, 48'h0}));
      check("reset big", 256'({b_in_ready, b_out_valid, b_busy, b_out}), 256'({3'b100, 240'h0}));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) small_req(tbl[i].m, tbl[i].k, tbl[i].r, tbl[i].exp, $sformatf("vec%0d", i));

      // Back-pressure with in_valid held high the whole time.
      s_msg = tbl[0].m; s_key = tbl[0].k; s_rotate = tbl[0].r;
      s_in_valid = 1'b1; s_out_ready = 1'b0;
      @(posedge clk);
      s_q.push_back(tbl[0].exp);
      @(negedge clk);
      cyc = 0;
      while (!s_out_valid && cyc < 20) begin
         check("bp in_ready in RUN", 256'(s_in_ready), 256'(0));
         @(negedge clk);
         cyc++;
      end
      check("bp latency", 256'(cyc), 256'(SN));
      held = (s_q.size() > 0) ? s_q.pop_front() : 'x;
      for (int i = 0; i < 5; i++) begin
         check("bp stall", 256'({s_out_valid, s_in_ready, s_out}), 256'({2'b10, held}));
         @(negedge clk);
      end
      s_out_ready = 1'b1;
      @(negedge clk);
      check("bp idle after ready", 256'({s_in_ready, s_out_valid}), 256'(2'b10));
      s_in_valid = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      check("bp single result", 256'({s_out_valid, s_busy, s_out}), 256'({2'b00, held}));

      // Reset after one processed block.
      s_msg = 48'hDEAD_BEEF_CAFE; s_key = 16'h1234; s_rotate = 1'b1; s_in_valid = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      s_in_valid = 1'b0;
      check("mid-run busy", 256'(s_busy), 256'(1));
      rst_n = 1'b0;
      #1;
      check("mid-run reset", 256'({s_out, s_out_valid, s_in_ready, s_busy}), 256'({48'h0, 3'b010}));
      @(negedge clk);
      rst_n = 1'b1;
      small_req(tbl[1].m, tbl[1].k, tbl[1].r, tbl[1].exp, "after reset");

      for (int n = 0; n < 100; n++) begin
         for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom;
         m = rnd[BM-1:0];
         k = BK'($urandom);
         r = 1'($urandom_range(0, 1));
         big_req(m, k, r, c);
         big_req(c, k, r, p);
         check("round trip", 256'(p), 256'(m));
      end

      check("scoreboard drained", 256'(s_q.size() + b_q.size()), 256'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
